// File: rtl/bw_io_bsr_seq.sv
// -----------------------------------------------------------------------------
// bw_io_bsr_seq
//
// Boundary-scan data-register sequencer for the I/O pad ring. It runs one
// scan operation at a time on the pad boundary-scan chain. It drives the
// shared chain controls (shift_dr, clock_dr, update_dr, mode_ctl, hiz_l) and
// the chain serial input. It also collects the bits that come out of the
// chain end.
//
// Operations (req_op):
//   00 SAMPLE_PRELOAD : capture, shift CHAIN_LEN bits, update; mode_ctl kept
//   01 EXTEST         : as above, then pads are driven from the BSR (mode_ctl=1)
//   10 HIGHZ          : tristate every pad (hiz_l=0), no chain activity
//   11 RELEASE        : give the pads back to the core (hiz_l=1, mode_ctl=0)
//
// Ports:
//   clk        in   core I/O clock
//   rst        in   asynchronous reset, active-high
//   req_valid  in   operation request
//   req_ready  out  sequencer idle and able to accept a request
//   req_op     in   [1:0] operation code (see above)
//   req_wdata  in   [CHAIN_LEN-1:0] data shifted into the chain, bit 0 first
//   rsp_valid  out  operation complete, response available
//   rsp_ready  in   consumer accepts the response (only looked at in DONE)
//   rsp_rdata  out  [CHAIN_LEN-1:0] data shifted out, bit 0 = first bit out
//   bsr_si     out  serial data into the chain
//   bso        in   serial data from the chain end
//   shift_dr   out  chain shift select
//   clock_dr   out  chain capture/shift strobe
//   update_dr  out  chain update strobe
//   mode_ctl   out  1 = pads driven from the boundary-scan register
//   hiz_l      out  0 = all pads tristated
//
// All outputs come straight from flops. Each output flop is loaded from the
// value its output must have in the state being entered.
// -----------------------------------------------------------------------------
module bw_io_bsr_seq #(
  parameter int CHAIN_LEN = 16,
  parameter int CNT_W     = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_op,
  input  logic [CHAIN_LEN-1:0] req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [CHAIN_LEN-1:0] rsp_rdata,
  output logic                 bsr_si,
  input  logic                 bso,
  output logic                 shift_dr,
  output logic                 clock_dr,
  output logic                 update_dr,
  output logic                 mode_ctl,
  output logic                 hiz_l
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_SHIFT,
    S_UPDATE,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    OP_SAMPLE_PRELOAD = 2'b00,
    OP_EXTEST         = 2'b01,
    OP_HIGHZ          = 2'b10,
    OP_RELEASE        = 2'b11
  } op_t;

  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CHAIN_LEN-1:0] BIT0     = CHAIN_LEN'(1);

  // FSM and operation context
  state_t               state_q, state_d;
  op_t                  op_q, op_d;
  logic [CHAIN_LEN-1:0] wdata_q, wdata_d;
  logic [CHAIN_LEN-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  // Registered outputs
  logic req_ready_q, req_ready_d;
  logic rsp_valid_q, rsp_valid_d;
  logic bsr_si_q, bsr_si_d;
  logic shift_dr_q, shift_dr_d;
  logic clock_dr_q, clock_dr_d;
  logic update_dr_q, update_dr_d;
  logic mode_ctl_q, mode_ctl_d;
  logic hiz_l_q, hiz_l_d;

  // Helpers for bit-by-cnt access without an over-wide index
  logic [CHAIN_LEN-1:0] cap_mask;
  logic [CHAIN_LEN-1:0] si_sel;

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    cnt_d      = cnt_q;
    mode_ctl_d = mode_ctl_q;
    hiz_l_d    = hiz_l_q;
    cap_mask   = BIT0 << cnt_q;
    si_sel     = '0;

    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          op_d    = op_t'(req_op);
          wdata_d = req_wdata;
          rdata_d = '0;
          case (op_t'(req_op))
            OP_SAMPLE_PRELOAD,
            OP_EXTEST: state_d = S_CAPTURE;
            OP_HIGHZ: begin
              // mode_ctl deliberately untouched
              hiz_l_d = 1'b0;
              state_d = S_DONE;
            end
            OP_RELEASE: begin
              hiz_l_d    = 1'b1;
              mode_ctl_d = 1'b0;
              state_d    = S_DONE;
            end
            default: state_d = S_IDLE;
          endcase
        end
      end

      S_CAPTURE: begin
        cnt_d   = '0;
        state_d = S_SHIFT;
      end

      S_SHIFT: begin
        // The chain end bit present during shift cycle cnt belongs in rdata[cnt]
        rdata_d = bso ? (rdata_q | cap_mask) : (rdata_q & ~cap_mask);
        if (cnt_q == CNT_LAST) begin
          // Park the counter; it never runs past the last cell
          cnt_d   = '0;
          state_d = S_UPDATE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_UPDATE: begin
        // Pads switch to BSR drive only once the new data has been updated
        if (op_q == OP_EXTEST) begin
          mode_ctl_d = 1'b1;
        end
        state_d = S_DONE;
      end

      S_DONE: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Output flops take the value belonging to the state being entered
    si_sel      = wdata_d >> cnt_d;
    req_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_DONE);
    shift_dr_d  = (state_d == S_SHIFT);
    clock_dr_d  = (state_d == S_CAPTURE) || (state_d == S_SHIFT);
    update_dr_d = (state_d == S_UPDATE);
    bsr_si_d    = (state_d == S_SHIFT) && si_sel[0];
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= OP_SAMPLE_PRELOAD;
      rdata_q     <= '0;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      bsr_si_q    <= 1'b0;
      shift_dr_q  <= 1'b0;
      clock_dr_q  <= 1'b0;
      update_dr_q <= 1'b0;
      mode_ctl_q  <= 1'b0;
      hiz_l_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      rdata_q     <= rdata_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      bsr_si_q    <= bsr_si_d;
      shift_dr_q  <= shift_dr_d;
      clock_dr_q  <= clock_dr_d;
      update_dr_q <= update_dr_d;
      mode_ctl_q  <= mode_ctl_d;
      hiz_l_q     <= hiz_l_d;
    end
  end

  // Write data is reloaded on every accepted request, so it needs no reset
  always_ff @(posedge clk) begin
    wdata_q <= wdata_d;
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign bsr_si    = bsr_si_q;
  assign shift_dr  = shift_dr_q;
  assign clock_dr  = clock_dr_q;
  assign update_dr = update_dr_q;
  assign mode_ctl  = mode_ctl_q;
  assign hiz_l     = hiz_l_q;

`ifndef SYNTHESIS
  a_no_strobe_overlap: assert property (@(posedge clk) disable iff (rst)
    !(clock_dr_q && update_dr_q));
  a_update_pulse: assert property (@(posedge clk) disable iff (rst)
    update_dr_q |=> !update_dr_q);
  a_shift_only_in_shift: assert property (@(posedge clk) disable iff (rst)
    shift_dr_q == (state_q == S_SHIFT));
  a_si_quiet: assert property (@(posedge clk) disable iff (rst)
    !shift_dr_q |-> !bsr_si_q);
  a_cnt_range: assert property (@(posedge clk) disable iff (rst)
    cnt_q <= CNT_LAST);
`endif

endmodule

// File: tb/tb_bw_io_bsr_seq.sv
module tb_bw_io_bsr_seq;

  localparam int CHAIN_LEN = 16;
  localparam int CNT_W     = 6;

  logic                 clk;
  logic                 rst;
  logic                 req_valid;
  logic                 req_ready;
  logic [1:0]           req_op;
  logic [CHAIN_LEN-1:0] req_wdata;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [CHAIN_LEN-1:0] rsp_rdata;
  logic                 bsr_si;
  logic                 bso;
  logic                 shift_dr;
  logic                 clock_dr;
  logic                 update_dr;
  logic                 mode_ctl;
  logic                 hiz_l;

  bw_io_bsr_seq #(.CHAIN_LEN(CHAIN_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .bsr_si(bsr_si), .bso(bso),
    .shift_dr(shift_dr), .clock_dr(clock_dr), .update_dr(update_dr),
    .mode_ctl(mode_ctl), .hiz_l(hiz_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model chain: shifts toward bso on clock_dr with shift_dr; capture does nothing
  logic [CHAIN_LEN-1:0] chain;
  logic                 load;
  logic [CHAIN_LEN-1:0] load_val;
  assign bso = chain[0];
  always @(posedge clk) begin
    if (load) chain <= load_val;
    else if (shift_dr && clock_dr) chain <= {bsr_si, chain[CHAIN_LEN-1:1]};
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic preload(input logic [CHAIN_LEN-1:0] v);
    @(negedge clk);
    load = 1'b1;
    load_val = v;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Issues one request, returns at the negedge where rsp_valid is first seen
  task automatic run_op(input logic [1:0] op, input logic [CHAIN_LEN-1:0] wd,
                        output int lat, output int nclk, output int nsh,
                        output int nupd, output int ovl, output logic mode_upd);
    lat = 1; nclk = 0; nsh = 0; nupd = 0; ovl = 0; mode_upd = 1'b0;
    @(negedge clk);
    req_op = op;
    req_wdata = wd;
    req_valid = 1'b1;
    check("req_ready_before_accept", req_ready, 1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    while (lat < 100) begin
      @(negedge clk);
      if (rsp_valid) break;
      nclk += int'(clock_dr);
      nsh  += int'(shift_dr);
      nupd += int'(update_dr);
      if (clock_dr && update_dr) ovl++;
      if (update_dr) mode_upd = mode_ctl;
      lat++;
    end
  endtask

  task automatic handshake(input logic exp_mode, input logic exp_hiz);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("hs_rsp_valid_drop", rsp_valid, 0);
    check("hs_req_ready", req_ready, 1);
    check("hs_mode_sticky", mode_ctl, exp_mode);
    check("hs_hiz_sticky", hiz_l, exp_hiz);
  endtask

  typedef struct {
    logic [1:0]           op;
    logic [CHAIN_LEN-1:0] wd;
    logic                 ld;
    logic [CHAIN_LEN-1:0] ldv;
    logic [CHAIN_LEN-1:0] rdata;
    logic [CHAIN_LEN-1:0] chain;
    int                   lat;
    logic                 mode;
    logic                 hiz;
  } vec_t;

  vec_t vecs[8];

  int   lat, nclk, nsh, nupd, ovl, nshift;
  logic mode_upd;
  logic prev_mode;
  logic is_scan;

  initial begin
    //          op     wd        ld    ldv       rdata     chain     lat mode  hiz
    vecs[0] = '{2'b00, 16'h1234, 1'b1, 16'hA5C3, 16'hA5C3, 16'h1234, 19, 1'b0, 1'b1};
    vecs[1] = '{2'b01, 16'hFFFF, 1'b0, 16'h0000, 16'h1234, 16'hFFFF, 19, 1'b1, 1'b1};
    vecs[2] = '{2'b11, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'hFFFF,  1, 1'b0, 1'b1};
    vecs[3] = '{2'b10, 16'hBEEF, 1'b0, 16'h0000, 16'h0000, 16'hFFFF,  1, 1'b0, 1'b0};
    vecs[4] = '{2'b00, 16'h00FF, 1'b1, 16'h5A3C, 16'h5A3C, 16'h00FF, 19, 1'b0, 1'b0};
    vecs[5] = '{2'b01, 16'h8001, 1'b0, 16'h0000, 16'h00FF, 16'h8001, 19, 1'b1, 1'b0};
    vecs[6] = '{2'b10, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h8001,  1, 1'b1, 1'b0};
    vecs[7] = '{2'b11, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h8001,  1, 1'b0, 1'b1};

    rst = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_wdata = '0;
    rsp_ready = 1'b0; load = 1'b0; load_val = '0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset release and idle
    repeat (5) @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_mode_ctl", mode_ctl, 0);
    check("rst_hiz_l", hiz_l, 1);
    check("rst_strobes", {bsr_si, shift_dr, clock_dr, update_dr}, 0);

    // Table-driven operation sequence
    prev_mode = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].ld) preload(vecs[i].ldv);
      run_op(vecs[i].op, vecs[i].wd, lat, nclk, nsh, nupd, ovl, mode_upd);
      is_scan = (vecs[i].op == 2'b00) || (vecs[i].op == 2'b01);
      check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("v%0d_clock_dr_cycles", i), nclk, is_scan ? 17 : 0);
      check($sformatf("v%0d_shift_dr_cycles", i), nsh, is_scan ? 16 : 0);
      check($sformatf("v%0d_update_dr_pulses", i), nupd, is_scan ? 1 : 0);
      check($sformatf("v%0d_strobe_overlap", i), ovl, 0);
      if (is_scan) check($sformatf("v%0d_mode_during_update", i), mode_upd, prev_mode);
      check($sformatf("v%0d_rsp_rdata", i), rsp_rdata, vecs[i].rdata);
      check($sformatf("v%0d_chain", i), chain, vecs[i].chain);
      check($sformatf("v%0d_mode_ctl", i), mode_ctl, vecs[i].mode);
      check($sformatf("v%0d_hiz_l", i), hiz_l, vecs[i].hiz);
      check($sformatf("v%0d_done_quiet", i), {req_ready, bsr_si, shift_dr, clock_dr, update_dr}, 0);
      handshake(vecs[i].mode, vecs[i].hiz);
      prev_mode = vecs[i].mode;
    end

    // Response held while a new request waits
    preload(16'h1357);
    run_op(2'b00, 16'h2468, lat, nclk, nsh, nupd, ovl, mode_upd);
    check("hold_latency", lat, 19);
    req_op = 2'b10;
    req_wdata = 16'h0000;
    req_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("hold_rsp_valid", rsp_valid, 1);
      check("hold_rsp_rdata", rsp_rdata, 16'h1357);
      check("hold_req_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("overlap_idle_rsp_valid", rsp_valid, 0);
    check("overlap_idle_req_ready", req_ready, 1);
    check("overlap_not_bypassed_hiz", hiz_l, 1);
    @(negedge clk);
    req_valid = 1'b0;
    check("overlap_accept_rsp_valid", rsp_valid, 1);
    check("overlap_accept_hiz", hiz_l, 0);
    check("overlap_accept_req_ready", req_ready, 0);
    handshake(1'b0, 1'b0);

    // EXTEST to set mode_ctl before the reset case
    run_op(2'b01, 16'h0F0F, lat, nclk, nsh, nupd, ovl, mode_upd);
    check("pre_rst_rdata", rsp_rdata, 16'h2468);
    handshake(1'b1, 1'b0);

    // Reset on the 7th shift cycle of an EXTEST
    @(negedge clk);
    req_op = 2'b01;
    req_wdata = 16'hAAAA;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    nshift = 0;
    for (int g = 0; g < 40; g++) begin
      @(negedge clk);
      if (shift_dr) nshift++;
      if (nshift == 7) break;
    end
    check("rst_mid_reached_shift7", nshift, 7);
    rst = 1'b1;
    #1;
    check("rst_mid_req_ready", req_ready, 1);
    check("rst_mid_rsp_valid", rsp_valid, 0);
    check("rst_mid_rsp_rdata", rsp_rdata, 0);
    check("rst_mid_strobes", {bsr_si, shift_dr, clock_dr, update_dr}, 0);
    check("rst_mid_mode_ctl", mode_ctl, 0);
    check("rst_mid_hiz_l", hiz_l, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rst_mid_no_response", rsp_valid, 0);
    end

    // Normal operation after the aborted one
    preload(16'h0BAD);
    run_op(2'b00, 16'h7777, lat, nclk, nsh, nupd, ovl, mode_upd);
    check("post_rst_latency", lat, 19);
    check("post_rst_rdata", rsp_rdata, 16'h0BAD);
    check("post_rst_chain", chain, 16'h7777);
    check("post_rst_clock_dr_cycles", nclk, 17);
    handshake(1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bw_io_bsr_seq.md
Name: bw_io_bsr_seq

Overview:
Boundary-scan data-register sequencer for a chain of CMOS I/O pad cells. It drives the chain control inputs of every pad's boundary-scan cell: shift_dr, clock_dr, update_dr, mode_ctl, hiz_l and the chain serial input. It collects the chain serial output. The block sits directly upstream of the pad ring and executes single-request scan operations issued by the I/O test/config logic.

Parameters:
CHAIN_LEN, 16, number of boundary-scan cells in the chain (2..64)
CNT_W, 6, shift counter width; must satisfy 2**CNT_W >= CHAIN_LEN

Ports:
clk  input  1  core I/O clock
rst  input  1  asynchronous reset, active-high
req_valid  input  1  operation request
req_ready  output  1  sequencer can accept a request
req_op  input  2  00 SAMPLE_PRELOAD, 01 EXTEST, 10 HIGHZ, 11 RELEASE
req_wdata  input  CHAIN_LEN  data to shift into chain, bit 0 shifted first
rsp_valid  output  1  operation complete
rsp_ready  input  1  consumer accepts response
rsp_rdata  output  CHAIN_LEN  captured chain data, bit 0 = first bit out
bsr_si  output  1  serial data into chain
bso  input  1  serial data from chain end
shift_dr  output  1  chain shift select
clock_dr  output  1  chain capture/shift strobe
update_dr  output  1  chain update strobe
mode_ctl  output  1  boundary-scan mode (1 = pads driven from BSR)
hiz_l  output  1  0 = all pads tristated

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- All outputs are registered.
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, bsr_si=0, shift_dr=0, clock_dr=0, update_dr=0, mode_ctl=0, hiz_l=1.
- FSM states: IDLE, CAPTURE, SHIFT, UPDATE, DONE.
- IDLE:
  - req_ready=1.
  - Request accepted on req_valid&req_ready. The block latches op and wdata, and clears rdata.
  - SAMPLE_PRELOAD or EXTEST -> CAPTURE.
  - HIGHZ -> DONE; hiz_l=0 from the next cycle.
  - RELEASE -> DONE; hiz_l=1 and mode_ctl=0 from the next cycle.
- CAPTURE (1 cycle): clock_dr=1, shift_dr=0. Shift counter cnt=0. -> SHIFT.
- SHIFT (exactly CHAIN_LEN cycles):
  - shift_dr=1, clock_dr=1, bsr_si=wdata[cnt].
  - At each edge, rdata[cnt] <= bso; cnt increments.
  - At cnt==CHAIN_LEN-1 -> UPDATE.
- UPDATE (1 cycle):
  - update_dr=1, shift_dr=0, clock_dr=0.
  - For EXTEST, mode_ctl=1 from the cycle after UPDATE.
  - For SAMPLE_PRELOAD, mode_ctl keeps its current value.
  - -> DONE.
- DONE:
  - rsp_valid=1, rsp_rdata held stable, req_ready=0.
  - When rsp_ready=1: rsp_valid drops at the next edge -> IDLE.
  - rsp_ready is ignored outside DONE.
- Latency: scan ops raise rsp_valid CHAIN_LEN+3 edges after acceptance. HIGHZ/RELEASE raise it 1 edge after acceptance.
- Strobe rules:
  - clock_dr and update_dr are never high in the same cycle.
  - update_dr is a single-cycle pulse.
  - shift_dr is only high in SHIFT.
  - bsr_si=0 outside SHIFT.
- Sticky state:
  - mode_ctl and hiz_l are sticky across operations; only EXTEST, HIGHZ, RELEASE or rst change them.
  - HIGHZ does not alter mode_ctl.
  - EXTEST does not alter hiz_l.
- Request interlock: req_valid while busy is not accepted (req_ready=0); the requester must hold it.
- Response/request overlap: simultaneous rsp_ready in DONE and a new req_valid means the new request is accepted only in the following IDLE cycle. There is no bypass.
- Reset mid-operation: asserting rst in any state forces reset values immediately, including mode_ctl=0 and hiz_l=1. Partial shift data is discarded; no response is produced.
- Counter: cnt never exceeds CHAIN_LEN-1 and does not wrap.

Test Plan:
1. Reset release, idle 5 cycles -> req_ready=1, rsp_valid=0, mode_ctl=0, hiz_l=1, all strobes 0.
2. CHAIN_LEN=16, bso driven by a 16-bit model chain preloaded with 0xA5C3, SAMPLE_PRELOAD with wdata=0x1234 ->
   - clock_dr high 17 cycles: 1 capture + 16 shift.
   - shift_dr high exactly 16 cycles, then a single update_dr pulse.
   - rsp_rdata=0xA5C3 (capture of 0xA5C3 with capture disabled in the model); chain holds 0x1234.
   - rsp_valid at edge 19; mode_ctl stays 0.
3. EXTEST wdata=0xFFFF -> mode_ctl rises the cycle after update_dr and remains 1 after the response handshake. A following RELEASE -> mode_ctl=0 one edge after acceptance.
4. HIGHZ -> hiz_l=0 one edge after acceptance and no clock_dr/shift_dr activity. A subsequent SAMPLE_PRELOAD keeps hiz_l=0.
5. Hold rsp_ready=0 for 10 cycles in DONE while req_valid=1 -> rsp_valid and rsp_rdata stable, req_ready=0. Then raise rsp_ready -> IDLE next edge, and the pending request is accepted one cycle later.
6. Assert rst on the 7th SHIFT cycle of an EXTEST -> all outputs at reset values in that cycle, no rsp_valid. A new request after deassertion completes normally.
